// File: rtl/instr_buffer.sv
// Two-wide fetch-to-decode instruction buffer: circular array with head/tail/count.
// Optional macro INSTR_BUFFER_PERF_EN adds the o_full_cycles stall counter.
module instr_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_PC1,
  input  logic [31:0] i_PC2,
  input  logic [31:0] i_instr1,
  input  logic [31:0] i_instr2,
  input  logic [33:0] i_brtype_pcpre_1,
  input  logic [33:0] i_brtype_pcpre_2,
  input  logic [7:0]  i_ecode_1,
  input  logic [7:0]  i_ecode_2,
  input  logic [1:0]  i_is_valid,
  input  logic        flush,
  input  logic        i_ready,
  output logic [31:0] o_PC1,
  output logic [31:0] o_PC2,
  output logic [31:0] o_instr1,
  output logic [31:0] o_instr2,
  output logic [33:0] o_brtype_pcpre_1,
  output logic [33:0] o_brtype_pcpre_2,
  output logic [7:0]  o_ecode_1,
  output logic [7:0]  o_ecode_2,
  output logic [1:0]  o_is_valid,
`ifdef INSTR_BUFFER_PERF_EN
  output logic [31:0] o_full_cycles,
`endif
  output logic        stall_full_instr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_TH = (AW+1)'(DEPTH - 2);

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    popcount2 = {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

  logic [105:0]  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          enq_en_s, deq_en_s;
  logic [1:0]    enq_n_s, deq_n_s;
  logic [AW-1:0] head1_s, slot2_addr_s;

  assign stall_full_instr = (count_q > FULL_TH);
  assign o_is_valid       = flush ? 2'b00 : {count_q >= (AW+1)'(2), count_q >= (AW+1)'(1)};

  assign enq_en_s     = !flush && !stall_full_instr;
  assign deq_en_s     = i_ready && !flush;
  assign enq_n_s      = enq_en_s ? popcount2(i_is_valid) : 2'd0;
  assign deq_n_s      = deq_en_s ? popcount2(o_is_valid) : 2'd0;
  assign head1_s      = head_q + AW'(1);
  // Slot 2 packs down to tail when slot 1 is empty.
  assign slot2_addr_s = i_is_valid[0] ? tail_q + AW'(1) : tail_q;

  assign {o_PC1, o_instr1, o_brtype_pcpre_1, o_ecode_1} = mem_q[head_q];
  assign {o_PC2, o_instr2, o_brtype_pcpre_2, o_ecode_2} = mem_q[head1_s];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(deq_n_s);
      tail_d  = tail_q + AW'(enq_n_s);
      count_d = count_q + (AW+1)'(enq_n_s) - (AW+1)'(deq_n_s);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is intentionally left unreset; only valid entries are ever observed.
  always_ff @(posedge clk) begin
    if (!rst && enq_en_s) begin
      if (i_is_valid[0]) begin
        mem_q[tail_q] <= {i_PC1, i_instr1, i_brtype_pcpre_1, i_ecode_1};
      end
      if (i_is_valid[1]) begin
        mem_q[slot2_addr_s] <= {i_PC2, i_instr2, i_brtype_pcpre_2, i_ecode_2};
      end
    end
  end

`ifdef INSTR_BUFFER_PERF_EN
  logic [31:0] full_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_cycles_q <= 32'd0;
    end else if (stall_full_instr) begin
      full_cycles_q <= full_cycles_q + 32'd1;
    end else begin
      full_cycles_q <= full_cycles_q;
    end
  end

  assign o_full_cycles = full_cycles_q;
`endif

endmodule

// File: tb/tb_instr_buffer.sv
// Bench for instr_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_instr_buffer;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_PC1, i_PC2, i_instr1, i_instr2;
  logic [33:0] i_brtype_pcpre_1, i_brtype_pcpre_2;
  logic [7:0]  i_ecode_1, i_ecode_2;
  logic [1:0]  i_is_valid;
  logic        flush, i_ready;
  logic [31:0] o_PC1, o_PC2, o_instr1, o_instr2;
  logic [33:0] o_brtype_pcpre_1, o_brtype_pcpre_2;
  logic [7:0]  o_ecode_1, o_ecode_2;
  logic [1:0]  o_is_valid;
  logic        stall_full_instr;
`ifdef INSTR_BUFFER_PERF_EN
  logic [31:0] o_full_cycles;
`endif

  int tests = 0;
  int fails = 0;

  instr_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_PC1(i_PC1), .i_PC2(i_PC2), .i_instr1(i_instr1), .i_instr2(i_instr2),
    .i_brtype_pcpre_1(i_brtype_pcpre_1), .i_brtype_pcpre_2(i_brtype_pcpre_2),
    .i_ecode_1(i_ecode_1), .i_ecode_2(i_ecode_2), .i_is_valid(i_is_valid),
    .flush(flush), .i_ready(i_ready),
    .o_PC1(o_PC1), .o_PC2(o_PC2), .o_instr1(o_instr1), .o_instr2(o_instr2),
    .o_brtype_pcpre_1(o_brtype_pcpre_1), .o_brtype_pcpre_2(o_brtype_pcpre_2),
    .o_ecode_1(o_ecode_1), .o_ecode_2(o_ecode_2), .o_is_valid(o_is_valid),
`ifdef INSTR_BUFFER_PERF_EN
    .o_full_cycles(o_full_cycles),
`endif
    .stall_full_instr(stall_full_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [105:0] act, input logic [105:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [105:0] entry_of(input logic [31:0] pc);
    entry_of = {pc, ~pc, {2'b10, pc ^ 32'h0000_0f00}, pc[9:2]};
  endfunction

  // Model: FIFO of entries; flush/reset empty it, enqueue blocked when full.
  logic [105:0] mq[$];
  logic [31:0]  perf_m = 32'd0;
  bit           started = 1'b0;

  always @(posedge clk) begin
    int  n;
    bit  full;
    full = (mq.size() > DEPTH - 2);
    if (rst) begin
      mq.delete();
      perf_m  = 32'd0;
      started = 1'b1;
    end else begin
      if (full) perf_m = perf_m + 32'd1;
      if (flush) begin
        mq.delete();
      end else begin
        n = i_ready ? ((mq.size() >= 2) ? 2 : mq.size()) : 0;
        repeat (n) void'(mq.pop_front());
        if (!full) begin
          if (i_is_valid[0]) mq.push_back({i_PC1, i_instr1, i_brtype_pcpre_1, i_ecode_1});
          if (i_is_valid[1]) mq.push_back({i_PC2, i_instr2, i_brtype_pcpre_2, i_ecode_2});
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] ev;
    if (started) begin
      ev = flush ? 2'b00 : {mq.size() >= 2, mq.size() >= 1};
      chk("m_valid", o_is_valid, ev);
      chk("m_stall", stall_full_instr, mq.size() > DEPTH - 2);
      if (ev[0]) chk("m_slot1", {o_PC1, o_instr1, o_brtype_pcpre_1, o_ecode_1}, mq[0]);
      if (ev[1]) chk("m_slot2", {o_PC2, o_instr2, o_brtype_pcpre_2, o_ecode_2}, mq[1]);
`ifdef INSTR_BUFFER_PERF_EN
      chk("m_perf", o_full_cycles, perf_m);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] v, input logic [31:0] pc1, input logic [31:0] pc2);
    i_is_valid = v;
    {i_PC1, i_instr1, i_brtype_pcpre_1, i_ecode_1} = entry_of(pc1);
    {i_PC2, i_instr2, i_brtype_pcpre_2, i_ecode_2} = entry_of(pc2);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; i_ready = 1'b0;
    put(2'b00, 32'h0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", o_is_valid, 2'b00);
    chk("rst_stall", stall_full_instr, 1'b0);
`ifdef INSTR_BUFFER_PERF_EN
    chk("rst_perf", o_full_cycles, 32'd0);
`endif
    // First pair after reset
    put(2'b11, 32'h1c000000, 32'h1c000004);
    tick(); put(2'b00, 32'h0, 32'h0); #1;
    chk("first_valid", o_is_valid, 2'b11);
    chk("first_pc1", o_PC1, 32'h1c000000);
    chk("first_pc2", o_PC2, 32'h1c000004);
    i_ready = 1'b1; tick(); i_ready = 1'b0;

    // Slot-2-only write lands at tail
    put(2'b10, 32'h1c000010, 32'h1c000014);
    #1;
    chk("no_bypass", o_is_valid, 2'b00);
    tick(); put(2'b00, 32'h0, 32'h0); #1;
    chk("s2_valid", o_is_valid, 2'b01);
    chk("s2_pc1", o_PC1, 32'h1c000014);
    i_ready = 1'b1; tick(); i_ready = 1'b0;

    // Fill until stalled; fifth pair must be dropped
    for (int k = 0; k < 5; k++) begin
      put(2'b11, 32'h1c000100 + 32'(8 * k), 32'h1c000104 + 32'(8 * k));
      tick(); #1;
      if (k == 2) chk("fill3_stall", stall_full_instr, 1'b0);
      if (k == 3) chk("fill4_stall", stall_full_instr, 1'b1);
    end
    put(2'b00, 32'h0, 32'h0);
    repeat (8) tick();
    chk("full_pc1", o_PC1, 32'h1c000100);
    i_ready = 1'b1; tick(); i_ready = 1'b0; #1;
    chk("drain_stall", stall_full_instr, 1'b0);
`ifdef INSTR_BUFFER_PERF_EN
    chk("perf_10", o_full_cycles, 32'd10);
`endif
    i_ready = 1'b1;
    tick(); tick(); #1;
    chk("tail_pc1", o_PC1, 32'h1c000118);
    chk("tail_pc2", o_PC2, 32'h1c00011c);
    tick(); i_ready = 1'b0; #1;
    chk("empty_valid", o_is_valid, 2'b00);

    // Simultaneous enqueue/dequeue at count 3, across the wrap
    put(2'b11, 32'h1c000200, 32'h1c000204); tick();
    put(2'b01, 32'h1c000208, 32'h0);        tick();
    i_ready = 1'b1;
    put(2'b11, 32'h1c00020c, 32'h1c000210); tick(); #1;
    chk("sim1_pc1", o_PC1, 32'h1c000208);
    chk("sim1_pc2", o_PC2, 32'h1c00020c);
    put(2'b11, 32'h1c000214, 32'h1c000218); tick();
    i_ready = 1'b0; put(2'b00, 32'h0, 32'h0); #1;
    chk("wrap_valid", o_is_valid, 2'b11);
    chk("wrap_pc1", o_PC1, 32'h1c000210);
    chk("wrap_pc2", o_PC2, 32'h1c000214);

    // Flush at count 5 beats enqueue and dequeue
    put(2'b11, 32'h1c000300, 32'h1c000304); tick();
    flush = 1'b1; i_ready = 1'b1;
    put(2'b11, 32'h1c000400, 32'h1c000404); #1;
    chk("flush_same", o_is_valid, 2'b00);
    tick(); flush = 1'b0; i_ready = 1'b0; put(2'b00, 32'h0, 32'h0); #1;
    chk("flush_after", o_is_valid, 2'b00);
`ifdef INSTR_BUFFER_PERF_EN
    chk("flush_perf", o_full_cycles, 32'd10);
`endif
    put(2'b11, 32'h1c000500, 32'h1c000504); tick();
    put(2'b00, 32'h0, 32'h0); #1;
    chk("post_flush_pc1", o_PC1, 32'h1c000500);

    // Reset mid-operation outranks flush and enqueue
    rst = 1'b1; flush = 1'b1; put(2'b11, 32'h1c000600, 32'h1c000604);
    tick(); rst = 1'b0; flush = 1'b0; put(2'b00, 32'h0, 32'h0); #1;
    chk("mid_rst_valid", o_is_valid, 2'b00);
`ifdef INSTR_BUFFER_PERF_EN
    chk("mid_rst_perf", o_full_cycles, 32'd0);
`endif
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_buffer.md
INSTR_BUFFER -- requirements
Module: instr_buffer

Interface
REQ-001 Parameter DEPTH, default 8, entry count; power of two, >=4.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_PC1, i_PC2  in  32  PCs of fetch slots 1/2 from the IF1/IF2 register.
REQ-005 i_instr1, i_instr2  in  32  instruction words from the ICache for slots 1/2.
REQ-006 i_brtype_pcpre_1, i_brtype_pcpre_2  in  34  branch type plus predicted PC per slot.
REQ-007 i_ecode_1, i_ecode_2  in  8  exception code per slot.
REQ-008 i_is_valid  in  2  bit0 = slot1 valid, bit1 = slot2 valid.
REQ-009 flush  in  1  branch or predecoder redirect; discards all contents.
REQ-010 i_ready  in  1  decode consumes every entry flagged in o_is_valid this cycle.
REQ-011 o_PC1, o_PC2, o_instr1, o_instr2, o_brtype_pcpre_1, o_brtype_pcpre_2, o_ecode_1, o_ecode_2  out  32/32/32/32/34/34/8/8  fields of head entry (slot 1) and head+1 entry (slot 2).
REQ-012 o_is_valid  out  2  bit0 = head entry valid, bit1 = head+1 entry valid.
REQ-013 stall_full_instr  out  1  upstream hold request; buffer cannot accept two entries.

Function
REQ-014 Storage SHALL be a circular array of DEPTH entries of 106 bits: PC, instr, brtype_pcpre, ecode.
REQ-015 State SHALL be head and tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
REQ-016 Pointers SHALL wrap modulo DEPTH with no bubble at the wrap boundary.
REQ-017 stall_full_instr SHALL equal (count > DEPTH-2), decoded from registered count only.
REQ-018 Enqueue SHALL occur when !flush && !stall_full_instr; valid slots are written in slot order starting at tail.
REQ-019 If only i_is_valid[1] is set, slot 2 SHALL be written alone at tail.
REQ-020 Enqueue count SHALL be popcount(i_is_valid); tail SHALL advance by the same amount.
REQ-021 While stall_full_instr is high, inputs SHALL be ignored; upstream holds them.
REQ-022 o_is_valid SHALL equal {count>=2, count>=1} masked to 2'b00 while flush is high.
REQ-023 Outputs SHALL be read combinationally from head and head+1 (mod DEPTH); zero-latency when count>=1.
REQ-024 Enqueued data SHALL first appear on the outputs the cycle after the write; no input-to-output bypass.
REQ-025 Dequeue SHALL occur when i_ready && !flush; dequeue count is popcount(o_is_valid); head advances by the same amount.
REQ-026 On simultaneous enqueue and dequeue, count SHALL become count + enq - deq.
REQ-027 count SHALL never exceed DEPTH or underflow.
REQ-028 When flush is high, head, tail and count SHALL be 0 next cycle.
REQ-029 Flush SHALL win over enqueue and dequeue in the same cycle.
REQ-030 Entry contents SHALL be don't-care when not valid.

Reset
REQ-031 While rst is high, head, tail and count SHALL go to 0 at the clock edge.
REQ-032 After reset: o_is_valid=2'b00, stall_full_instr=0, perf counter (if present)=0.
REQ-033 Storage array SHALL not be reset.
REQ-034 rst mid-operation SHALL discard all entries and take precedence over flush, enqueue and dequeue.

Configuration
REQ-035 Macro INSTR_BUFFER_PERF_EN defined: add output o_full_cycles (32 bits).
- Increments each cycle stall_full_instr=1; wraps at 2^32.
- Cleared by rst only; unaffected by flush.
REQ-036 Macro INSTR_BUFFER_PERF_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-037 Reset: rst=1 two cycles, then i_is_valid=2'b11 with PC 0x1c000000/0x1c000004 -> next cycle o_is_valid=2'b11, o_PC1=0x1c000000, o_PC2=0x1c000004.
REQ-038 Fill: i_ready=0, i_is_valid=2'b11 each cycle, DEPTH=8 -> stall_full_instr=1 after 4 enqueues (count=8); fifth pair not stored.
REQ-039 Slot-2-only: i_is_valid=2'b10 with PC 0x1c000014 into empty buffer -> next cycle o_is_valid=2'b01, o_PC1=0x1c000014.
REQ-040 Simultaneous: count=3, i_ready=1, enqueue 2 -> count=3 next cycle; order preserved.
- Run across the wrap with head=7 -> o_PC2 taken from entry 0.
REQ-041 Flush: count=5, flush=1 with i_is_valid=2'b11 and i_ready=1 -> o_is_valid=2'b00 same cycle; count=0 next cycle; nothing enqueued.
REQ-042 Perf (INSTR_BUFFER_PERF_EN defined): hold full for 10 cycles -> o_full_cycles=10; flush leaves it at 10; rst clears it to 0.
